// File: rtl/store_commit_if.sv
// Store-commit bus: ROB head store handshake plus the memory write port.
// Handshake semantics: a store is offered while store_valid_in is high and is
// consumed by the single-cycle store_read_out pulse; a memory write is offered
// while mem_req_out is high and is accepted in the cycle mem_gnt_in is high,
// after which mem_done_in marks completion.
interface store_commit_if #(
    parameter int ADDR_W   = 30,
    parameter int ROB_IX_W = 3
);
    logic                store_valid_in;
    logic [ROB_IX_W-1:0] store_ix_in;
    logic [31:0]         store_value_in;
    logic [31:0]         store_dest_in;
    logic [1:0]          store_size_in;
    logic                store_read_out;
    logic                mem_req_out;
    logic [ADDR_W-1:0]   mem_addr_out;
    logic [31:0]         mem_wdata_out;
    logic [3:0]          mem_be_out;
    logic                mem_gnt_in;
    logic                mem_done_in;

    // Environment side: ROB head and memory.
    modport master (
        output store_valid_in, store_ix_in, store_value_in, store_dest_in,
               store_size_in, mem_gnt_in, mem_done_in,
        input  store_read_out, mem_req_out, mem_addr_out, mem_wdata_out,
               mem_be_out
    );

    // Store-commit unit side.
    modport slave (
        input  store_valid_in, store_ix_in, store_value_in, store_dest_in,
               store_size_in, mem_gnt_in, mem_done_in,
        output store_read_out, mem_req_out, mem_addr_out, mem_wdata_out,
               mem_be_out
    );
endinterface

// File: rtl/store_commit.sv
// Store commit unit: takes the ready store at the ROB head, issues one
// byte-lane-aligned memory write, waits for completion, then acknowledges the
// ROB with a single store_read_out pulse.
// Optional feature: define STORE_MISALIGN_TRAP_EN to drop misaligned stores
// (no memory write, misaligned_out pulses alongside store_read_out).
module store_commit #(
    parameter int ADDR_W   = 30,
    parameter int ROB_IX_W = 3
) (
    input  logic                clk_in,
    input  logic                rst_in,
    store_commit_if.slave       bus,
    output logic                busy_out,
    output logic                misaligned_out,
    output logic [15:0]         commit_count_out,
    output logic [1:0]          state_out,
    output logic [ROB_IX_W-1:0] head_ix_out
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_ACK = 2'd3} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic [ROB_IX_W-1:0] r_ix;
    logic                r_drop;
    logic [15:0]         r_count;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic                w_drop;
    logic                w_req;
    logic                w_read;
    logic                w_busy;

    // Lane steering: byte enables and replicated write data from size and low address bits.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.store_value_in;
        case (bus.store_size_in)
            2'd0: begin
                w_be    = 4'b0001 << bus.store_dest_in[1:0];
                w_wdata = {4{bus.store_value_in[7:0]}};
            end
            2'd1: begin
                w_be    = bus.store_dest_in[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.store_value_in[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = bus.store_value_in;
            end
        endcase
    end

`ifdef STORE_MISALIGN_TRAP_EN
    logic w_misaligned;

    // Misalignment: half on an odd byte, word (or reserved size) off a word boundary.
    always_comb begin
        w_misaligned = 1'b0;
        case (bus.store_size_in)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = bus.store_dest_in[0];
            default: w_misaligned = |bus.store_dest_in[1:0];
        endcase
    end

    assign w_drop = w_misaligned;
`else
    // Misaligned stores are written with the low address bits truncated.
    assign w_drop = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: valid is only looked at in IDLE; done only in WAIT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.store_valid_in) w_next = w_drop ? S_ACK : S_REQ;
            S_REQ:  if (bus.mem_gnt_in)     w_next = S_WAIT;
            S_WAIT: if (bus.mem_done_in)    w_next = S_ACK;
            S_ACK:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        w_req  = 1'b0;
        w_read = 1'b0;
        w_busy = 1'b1;
        case (r_state)
            S_IDLE: w_busy = 1'b0;
            S_REQ:  w_req  = 1'b1;
            S_WAIT: w_req  = 1'b0;
            S_ACK:  w_read = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    // Capture the head store in IDLE; held stable through REQ and after completion.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_ix    <= '0;
            r_drop  <= 1'b0;
        end else if (r_state == S_IDLE && bus.store_valid_in) begin
            r_addr  <= bus.store_dest_in[ADDR_W+1:2];
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_ix    <= bus.store_ix_in;
            r_drop  <= w_drop;
        end
    end

    // Commit counter: one per ROB acknowledge, wraps at 16 bits.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_count <= '0;
        end else if (r_state == S_ACK) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign bus.mem_req_out    = w_req;
    assign bus.store_read_out = w_read;
    assign bus.mem_addr_out   = r_addr;
    assign bus.mem_wdata_out  = r_wdata;
    assign bus.mem_be_out     = r_be;
    assign busy_out           = w_busy;
    assign misaligned_out     = w_read & r_drop;
    assign commit_count_out   = r_count;
    assign state_out          = r_state;
    assign head_ix_out        = r_ix;
endmodule

// File: tb/tb_store_commit.sv
// Bench for store_commit: table of directed stores plus hand-written
// sequences for back-to-back, spurious done, and reset during WAIT.
module tb_store_commit;
    localparam int ADDR_W   = 30;
    localparam int ROB_IX_W = 3;
`ifdef STORE_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Clock and reset
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int cycle = 0;
    always @(posedge clk_in) cycle <= cycle + 1;

    store_commit_if #(.ADDR_W(ADDR_W), .ROB_IX_W(ROB_IX_W)) bus ();

    logic                busy_out;
    logic                misaligned_out;
    logic [15:0]         commit_count_out;
    logic [1:0]          state_out;
    logic [ROB_IX_W-1:0] head_ix_out;

    store_commit #(.ADDR_W(ADDR_W), .ROB_IX_W(ROB_IX_W)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .bus              (bus.slave),
        .busy_out         (busy_out),
        .misaligned_out   (misaligned_out),
        .commit_count_out (commit_count_out),
        .state_out        (state_out),
        .head_ix_out      (head_ix_out)
    );

    // Scoreboard
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_count = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0]         value;
        logic [31:0]         dest;
        logic [1:0]          size;
        int                  gnt_wait;
        int                  done_wait;
        logic [ROB_IX_W-1:0] ix;
        logic [ADDR_W-1:0]   exp_addr;
        logic [3:0]          exp_be;
        logic [31:0]         exp_wdata;
        bit                  exp_mis;
    } vec_t;

    vec_t vecs[8];

    // Driver: offer one store, run the memory side with the given delays, check every cycle.
    task automatic run_store(input vec_t v, input string tag);
        bit drop;
        int c0;
        drop = TRAP && v.exp_mis;
        @(negedge clk_in);
        bus.store_valid_in = 1'b1;
        bus.store_value_in = v.value;
        bus.store_dest_in  = v.dest;
        bus.store_size_in  = v.size;
        bus.store_ix_in    = v.ix;
        c0 = cycle;
        @(negedge clk_in);
        bus.store_valid_in = 1'b0;
        chk({tag, "_ix"}, 32'(head_ix_out), 32'(v.ix));
        if (drop) begin
            chk({tag, "_drop_req"}, 32'(bus.mem_req_out), 32'd0);
            chk({tag, "_drop_read"}, 32'(bus.store_read_out), 32'd1);
            chk({tag, "_drop_mis"}, 32'(misaligned_out), 32'd1);
            exp_count++;
            @(negedge clk_in);
            chk({tag, "_drop_read_end"}, 32'(bus.store_read_out), 32'd0);
            chk({tag, "_drop_count"}, 32'(commit_count_out), 32'(exp_count));
            return;
        end
        chk({tag, "_req"}, 32'(bus.mem_req_out), 32'd1);
        chk({tag, "_busy"}, 32'(busy_out), 32'd1);
        chk({tag, "_addr"}, 32'(bus.mem_addr_out), 32'(v.exp_addr));
        chk({tag, "_be"}, 32'(bus.mem_be_out), 32'(v.exp_be));
        chk({tag, "_wdata"}, bus.mem_wdata_out, v.exp_wdata);
        chk({tag, "_mis"}, 32'(misaligned_out), 32'd0);
        for (int k = 0; k < v.gnt_wait; k++) begin
            @(negedge clk_in);
            chk({tag, "_stall_req"}, 32'(bus.mem_req_out), 32'd1);
            chk({tag, "_stall_addr"}, 32'(bus.mem_addr_out), 32'(v.exp_addr));
            chk({tag, "_stall_be"}, 32'(bus.mem_be_out), 32'(v.exp_be));
            chk({tag, "_stall_wdata"}, bus.mem_wdata_out, v.exp_wdata);
            chk({tag, "_stall_read"}, 32'(bus.store_read_out), 32'd0);
        end
        bus.mem_gnt_in = 1'b1;
        @(negedge clk_in);
        bus.mem_gnt_in = 1'b0;
        chk({tag, "_wait_req"}, 32'(bus.mem_req_out), 32'd0);
        chk({tag, "_wait_read"}, 32'(bus.store_read_out), 32'd0);
        for (int k = 0; k < v.done_wait; k++) begin
            @(negedge clk_in);
            chk({tag, "_wait2_req"}, 32'(bus.mem_req_out), 32'd0);
            chk({tag, "_wait2_read"}, 32'(bus.store_read_out), 32'd0);
        end
        bus.mem_done_in = 1'b1;
        @(negedge clk_in);
        bus.mem_done_in = 1'b0;
        chk({tag, "_ack_read"}, 32'(bus.store_read_out), 32'd1);
        chk({tag, "_ack_req"}, 32'(bus.mem_req_out), 32'd0);
        chk({tag, "_ack_mis"}, 32'(misaligned_out), 32'd0);
        chk({tag, "_latency"}, 32'(cycle - c0), 32'(3 + v.gnt_wait + v.done_wait));
        exp_count++;
        @(negedge clk_in);
        chk({tag, "_read_end"}, 32'(bus.store_read_out), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy_out), 32'd0);
        chk({tag, "_hold_wdata"}, bus.mem_wdata_out, v.exp_wdata);
        chk({tag, "_count"}, 32'(commit_count_out), 32'(exp_count));
    endtask

    int c_first;
    int c_second;

    initial begin
        //                value         dest          sz  gw dw ix    addr         be       wdata         mis
        vecs[0] = '{32'h0000_00AB, 32'h0000_1003, 2'd0, 0, 0, 3'd1, 30'h400, 4'b1000, 32'hABAB_ABAB, 1'b0};
        vecs[1] = '{32'h0000_1234, 32'h0000_2002, 2'd1, 5, 0, 3'd2, 30'h800, 4'b1100, 32'h1234_1234, 1'b0};
        vecs[2] = '{32'hDEAD_BEEF, 32'h0000_0010, 2'd2, 1, 2, 3'd3, 30'h004, 4'b1111, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{32'hCAFE_F00D, 32'h0000_0024, 2'd3, 0, 1, 3'd4, 30'h009, 4'b1111, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{32'h5566_7788, 32'h0000_0000, 2'd0, 2, 0, 3'd5, 30'h000, 4'b0001, 32'h8888_8888, 1'b0};
        vecs[5] = '{32'hFFFF_A5A5, 32'h0000_0040, 2'd1, 0, 0, 3'd6, 30'h010, 4'b0011, 32'hA5A5_A5A5, 1'b0};
        vecs[6] = '{32'h1122_3344, 32'h0000_3001, 2'd2, 0, 0, 3'd7, 30'hC00, 4'b1111, 32'h1122_3344, 1'b1};
        vecs[7] = '{32'h0000_BEEF, 32'h0000_0005, 2'd1, 1, 0, 3'd0, 30'h001, 4'b0011, 32'hBEEF_BEEF, 1'b1};

        bus.store_valid_in = 1'b0;
        bus.store_ix_in    = '0;
        bus.store_value_in = '0;
        bus.store_dest_in  = '0;
        bus.store_size_in  = '0;
        bus.mem_gnt_in     = 1'b0;
        bus.mem_done_in    = 1'b0;

        // Reset state
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("rst_req", 32'(bus.mem_req_out), 32'd0);
        chk("rst_read", 32'(bus.store_read_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_mis", 32'(misaligned_out), 32'd0);
        chk("rst_count", 32'(commit_count_out), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr_out), 32'd0);
        chk("rst_be", 32'(bus.mem_be_out), 32'd0);
        chk("rst_wdata", bus.mem_wdata_out, 32'd0);
        chk("rst_state", 32'(state_out), 32'd0);
        rst_in = 1'b1;

        // Table of directed stores
        for (int i = 0; i < 8; i++) begin
            run_store(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: valid held high across ACK, head advances on the read pulse
        @(negedge clk_in);
        bus.store_valid_in = 1'b1;
        bus.store_value_in = 32'h0000_0011;
        bus.store_dest_in  = 32'h0000_0100;
        bus.store_size_in  = 2'd2;
        bus.store_ix_in    = 3'd2;
        @(negedge clk_in);
        chk("b2b_a_addr", 32'(bus.mem_addr_out), 32'h40);
        chk("b2b_a_req", 32'(bus.mem_req_out), 32'd1);
        bus.mem_gnt_in = 1'b1;
        @(negedge clk_in);
        bus.mem_gnt_in  = 1'b0;
        bus.mem_done_in = 1'b1;
        @(negedge clk_in);
        bus.mem_done_in = 1'b0;
        chk("b2b_a_read", 32'(bus.store_read_out), 32'd1);
        c_first = cycle;
        bus.store_value_in = 32'h0000_0022;
        bus.store_dest_in  = 32'h0000_0200;
        bus.store_ix_in    = 3'd3;
        @(negedge clk_in);
        chk("b2b_idle_req", 32'(bus.mem_req_out), 32'd0);
        chk("b2b_idle_busy", 32'(busy_out), 32'd0);
        chk("b2b_idle_addr", 32'(bus.mem_addr_out), 32'h40);
        @(negedge clk_in);
        chk("b2b_b_req", 32'(bus.mem_req_out), 32'd1);
        chk("b2b_b_addr", 32'(bus.mem_addr_out), 32'h80);
        chk("b2b_b_wdata", bus.mem_wdata_out, 32'h0000_0022);
        bus.mem_gnt_in = 1'b1;
        @(negedge clk_in);
        bus.mem_gnt_in  = 1'b0;
        bus.mem_done_in = 1'b1;
        @(negedge clk_in);
        bus.mem_done_in    = 1'b0;
        bus.store_valid_in = 1'b0;
        chk("b2b_b_read", 32'(bus.store_read_out), 32'd1);
        c_second = cycle;
        chk("b2b_spacing", 32'(c_second - c_first), 32'd4);
        exp_count = exp_count + 16'd2;
        @(negedge clk_in);
        chk("b2b_count", 32'(commit_count_out), 32'(exp_count));
        chk("b2b_no_third", 32'(busy_out), 32'd0);

        // Spurious done in IDLE and in REQ
        bus.mem_done_in = 1'b1;
        repeat (2) @(negedge clk_in);
        chk("spur_idle_busy", 32'(busy_out), 32'd0);
        chk("spur_idle_read", 32'(bus.store_read_out), 32'd0);
        chk("spur_idle_count", 32'(commit_count_out), 32'(exp_count));
        bus.mem_done_in    = 1'b0;
        bus.store_valid_in = 1'b1;
        bus.store_value_in = 32'h0000_00C3;
        bus.store_dest_in  = 32'h0000_0401;
        bus.store_size_in  = 2'd0;
        @(negedge clk_in);
        bus.store_valid_in = 1'b0;
        bus.mem_done_in    = 1'b1;
        @(negedge clk_in);
        bus.mem_done_in = 1'b0;
        chk("spur_req_state", 32'(state_out), 32'd1);
        chk("spur_req_req", 32'(bus.mem_req_out), 32'd1);
        chk("spur_req_be", 32'(bus.mem_be_out), 32'b0010);
        bus.mem_gnt_in = 1'b1;
        @(negedge clk_in);
        bus.mem_gnt_in  = 1'b0;
        bus.mem_done_in = 1'b1;
        @(negedge clk_in);
        bus.mem_done_in = 1'b0;
        chk("spur_ack_read", 32'(bus.store_read_out), 32'd1);
        exp_count++;
        @(negedge clk_in);
        chk("spur_count", 32'(commit_count_out), 32'(exp_count));

        // Reset during WAIT, with done arriving in the same cycle
        bus.store_valid_in = 1'b1;
        bus.store_value_in = 32'h7777_7777;
        bus.store_dest_in  = 32'h0000_0800;
        bus.store_size_in  = 2'd2;
        @(negedge clk_in);
        bus.store_valid_in = 1'b0;
        bus.mem_gnt_in     = 1'b1;
        @(negedge clk_in);
        bus.mem_gnt_in = 1'b0;
        chk("rw_wait_state", 32'(state_out), 32'd2);
        rst_in          = 1'b0;
        bus.mem_done_in = 1'b1;
        @(negedge clk_in);
        rst_in          = 1'b1;
        bus.mem_done_in = 1'b0;
        exp_count       = 16'd0;
        chk("rw_req", 32'(bus.mem_req_out), 32'd0);
        chk("rw_read", 32'(bus.store_read_out), 32'd0);
        chk("rw_busy", 32'(busy_out), 32'd0);
        chk("rw_count", 32'(commit_count_out), 32'd0);
        chk("rw_addr", 32'(bus.mem_addr_out), 32'd0);
        chk("rw_be", 32'(bus.mem_be_out), 32'd0);
        chk("rw_wdata", bus.mem_wdata_out, 32'd0);
        @(negedge clk_in);
        chk("rw_no_late_read", 32'(bus.store_read_out), 32'd0);
        run_store(vecs[0], "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog: the sequences above are fixed-length, this only guards against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
